// File: rtl/ppl_pixel_writeback.sv
// Ray-pipeline writeback: buffers retired pixels, converts them to RGB444 and writes the display RAM.
// Defining WB_FRAME_SWAP_EN turns on double buffering (the bank flips after each end-of-frame write).

`ifndef DISP_RAM_ADDR_RADIX
`define DISP_RAM_ADDR_RADIX 8
`endif
`ifndef EOF_ADDR
`define EOF_ADDR 255
`endif

module ppl_pixel_writeback #(
  parameter int ADDR_W        = `DISP_RAM_ADDR_RADIX,
  parameter int EOF_ADDR      = `EOF_ADDR,
  parameter int PIX_PER_FRAME = `EOF_ADDR + 1,
  parameter int FIFO_DEPTH    = 4,
  parameter int SWAP_GAP      = 2
) (
  input  logic              clk_ppl,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_color_acc,
  output logic              in_ready,
  output logic              ram_we,
  output logic [ADDR_W:0]   ram_addr,
  output logic [11:0]       ram_data,
  output logic              frame_done,
  output logic              frame_err,
  output logic [15:0]       frame_cnt,
  output logic              disp_bank,
  output logic              busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int PIX_W = ADDR_W + 1;
  localparam int GAP_W = (SWAP_GAP > 1) ? $clog2(SWAP_GAP) : 1;
  localparam int ENT_W = ADDR_W + 12;

  localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] EOF_C      = ADDR_W'(EOF_ADDR);
  localparam logic [PIX_W:0]    PPF_C      = (PIX_W + 1)'(PIX_PER_FRAME);
  localparam logic [GAP_W-1:0]  GAP_LAST_C = GAP_W'(SWAP_GAP - 1);

  typedef enum logic {ST_RUN, ST_GAP} state_t;

  state_t             state_q, state_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PIX_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic               frame_err_q, frame_err_d;
  logic               ram_we_q, ram_we_d;
  logic               frame_done_q, frame_done_d;
  logic [ADDR_W:0]    ram_addr_q, ram_addr_d;
  logic [11:0]        ram_data_q, ram_data_d;

  logic [ENT_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [11:0]        in_rgb;
  logic [ADDR_W-1:0]  head_addr;
  logic [11:0]        head_rgb;
  logic               push, pop, pop_eof, cur_bank;
  logic [19:0]        unused_color_lsbs;

  // Any saturation bit forces white; otherwise keep the top nibble of each channel.
  assign in_rgb = (|in_color_acc[31:24]) ? 12'hFFF
                : {in_color_acc[23:20], in_color_acc[15:12], in_color_acc[7:4]};
  assign unused_color_lsbs = {in_color_acc[19:16], in_color_acc[11:8], in_color_acc[3:0],
                              in_color_acc[31:24]};

  assign in_ready  = (count_q < DEPTH_C);
  assign push      = in_valid & in_ready;
  assign pop       = (state_q == ST_RUN) & enable & (count_q != '0);
  assign head_addr = fifo_mem[rd_ptr_q][ENT_W-1:12];
  assign head_rgb  = fifo_mem[rd_ptr_q][11:0];
  assign pop_eof   = pop & (head_addr == EOF_C);

  always_ff @(posedge clk_ppl) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {in_addr, in_rgb};
    end
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    state_d      = state_q;
    gap_d        = gap_q;
    pix_cnt_d    = pix_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    frame_err_d  = frame_err_q;
    ram_we_d     = pop;
    frame_done_d = pop_eof;
    ram_addr_d   = ram_addr_q;
    ram_data_d   = ram_data_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      ram_addr_d = {cur_bank, head_addr};
      ram_data_d = head_rgb;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (pop_eof) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
      frame_err_d = (({1'b0, pix_cnt_q} + (PIX_W + 1)'(1)) != PPF_C);
      pix_cnt_d   = '0;
    end else if (pop && !(&pix_cnt_q)) begin
      pix_cnt_d = pix_cnt_q + PIX_W'(1);
    end

    case (state_q)
      ST_RUN: begin
        if (pop_eof) begin
          state_d = ST_GAP;
          gap_d   = '0;
        end
      end
      ST_GAP: begin
        // Counts regardless of enable so a stalled drain side cannot stretch the swap gap.
        if (gap_q == GAP_LAST_C) begin
          state_d = ST_RUN;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_ppl or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      gap_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pix_cnt_q    <= '0;
      frame_cnt_q  <= '0;
      frame_err_q  <= 1'b0;
      ram_we_q     <= 1'b0;
      frame_done_q <= 1'b0;
      ram_addr_q   <= '0;
      ram_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      gap_q        <= gap_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      pix_cnt_q    <= pix_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_err_q  <= frame_err_d;
      ram_we_q     <= ram_we_d;
      frame_done_q <= frame_done_d;
      ram_addr_q   <= ram_addr_d;
      ram_data_q   <= ram_data_d;
    end
  end

`ifdef WB_FRAME_SWAP_EN
  logic bank_q;

  // Flip once the EOF write is on the bus, so the EOF pixel still lands in the old bank.
  always_ff @(posedge clk_ppl or negedge rst_n) begin
    if (!rst_n) begin
      bank_q <= 1'b0;
    end else if (frame_done_q) begin
      bank_q <= ~bank_q;
    end
  end

  assign cur_bank  = bank_q;
  assign disp_bank = ~bank_q;
`else
  assign cur_bank  = 1'b0;
  assign disp_bank = 1'b0;
`endif

  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_data   = ram_data_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign frame_cnt  = frame_cnt_q;
  assign busy       = (count_q != '0) | ram_we_q | (state_q == ST_GAP);

endmodule
